// File: rtl/mod5_pkg.sv
// Shared types and constants for the mod-5 byte sequencer.
// The FSM states and sizing constants live here.
package mod5_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int MODULUS    = 5;
  localparam int REM_WIDTH  = $clog2(MODULUS);
  localparam int CNT_WIDTH  = $clog2(BYTE_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    RESULT
  } state_t;

endpackage

// File: rtl/mod5_byte_sequencer_if.sv
// Byte-in, result-out and shift-register link of the sequencer.
// slave is the sequencer view, master the surrounding wrapper view.
interface mod5_byte_sequencer_if;
  import mod5_pkg::*;

  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  logic [BYTE_WIDTH-1:0] reg_parallel_in;
  logic                  reg_catch_in;
  logic                  reg_en;
  logic                  reg_output_bit;

  logic                  result_valid;
  logic [REM_WIDTH-1:0]  result_remainder;
  logic                  result_divisible;
  logic                  result_ready;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output reg_parallel_in, reg_catch_in, reg_en,
    input  reg_output_bit,
    output result_valid, result_remainder,
    output result_divisible,
    input  result_ready
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  reg_parallel_in, reg_catch_in, reg_en,
    output reg_output_bit,
    input  result_valid, result_remainder,
    input  result_divisible,
    output result_ready
  );

endinterface

// File: rtl/mod5_remainder_step.sv
// One MSB-first step of a running remainder: (2*acc + bit) mod MODULUS.
// acc < MODULUS keeps 2*acc+1 below 2*MODULUS, so one subtract suffices.
module mod5_remainder_step #(
  parameter  int MODULUS = 5,
  localparam int RW      = $clog2(MODULUS)
) (
  input  logic [RW-1:0] i_acc,
  input  logic          i_bit,
  output logic [RW-1:0] o_acc
);

  logic [RW:0] w_dbl;
  logic [RW:0] w_sub;
  logic        w_ge;

  assign w_dbl = {i_acc, i_bit};
  assign w_ge  = (w_dbl >= (RW+1)'(MODULUS));
  assign w_sub = w_dbl - (RW+1)'(MODULUS);
  assign o_acc = w_ge ? w_sub[RW-1:0] : w_dbl[RW-1:0];

endmodule

// File: rtl/mod5_byte_sequencer.sv
// Streams bytes through an external MSB-first shift register and
// folds its serial output into a per-frame remainder mod MODULUS.
module mod5_byte_sequencer
  import mod5_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  mod5_byte_sequencer_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [BYTE_WIDTH-1:0] r_byte_hold;
  logic                  r_last_hold;
  logic [REM_WIDTH-1:0]  r_acc;
  logic [REM_WIDTH-1:0]  w_acc_step;
  logic [REM_WIDTH-1:0]  w_rem;
  logic                  w_sample;
  logic                  w_accept;
  logic                  w_release;

  mod5_remainder_step #(
    .MODULUS (MODULUS)
  ) u_step (
    .i_acc (r_acc),
    .i_bit (bus.reg_output_bit),
    .o_acc (w_acc_step)
  );

  always_comb begin
    w_state_next        = r_state;
    w_sample            = 1'b0;
    w_rem               = '0;
    bus.in_ready        = 1'b0;
    bus.reg_en          = 1'b0;
    bus.reg_catch_in    = 1'b0;
    bus.reg_parallel_in = '0;
    bus.result_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          w_state_next = LOAD;
      end
      LOAD: begin
        bus.reg_en          = 1'b1;
        bus.reg_catch_in    = 1'b1;
        bus.reg_parallel_in = r_byte_hold;
        w_state_next        = SHIFT;
      end
      SHIFT: begin
        bus.reg_en = 1'b1;
        // first shift cycle still shows the previous register output
        w_sample   = (r_cnt != '0);
        if (r_cnt == CNT_WIDTH'(BYTE_WIDTH - 1))
          w_state_next = DRAIN;
      end
      DRAIN: begin
        w_sample     = 1'b1;
        w_state_next = r_last_hold ? RESULT : IDLE;
      end
      RESULT: begin
        bus.result_valid = 1'b1;
        w_rem            = r_acc;
        if (bus.result_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.result_remainder = w_rem;
  assign bus.result_divisible = (w_rem == '0);

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_release = (r_state == RESULT) && bus.result_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_byte_hold <= '0;
      r_last_hold <= 1'b0;
      r_acc       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_byte_hold <= bus.in_data;
        r_last_hold <= bus.in_last;
      end
      if (r_state == LOAD)
        r_cnt <= '0;
      else if (r_state == SHIFT)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_sample)
        r_acc <= w_acc_step;
      else if (w_release)
        r_acc <= '0;
    end
  end

endmodule

// File: tb/tb_mod5_byte_sequencer.sv
// Directed bench: behavioural shift register beside the sequencer,
// expected remainders queued at send time and checked on result.
module tb_mod5_byte_sequencer;
  import mod5_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  int unsigned exp_q[$];

  int en_cnt    = 0;
  int catch_cnt = 0;
  logic stray   = 1'b0;

  logic [7:0] sr = 8'h00;
  logic       so = 1'b0;

  mod5_byte_sequencer_if bus ();

  mod5_byte_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // external MSB-first register with registered serial output
  always @(posedge clock) begin
    if (bus.reg_en) begin
      if (bus.reg_catch_in) begin
        sr <= bus.reg_parallel_in;
      end else begin
        so <= sr[7];
        sr <= {sr[6:0], 1'b0};
      end
    end
  end
  assign bus.reg_output_bit = so;

  always @(posedge clock) begin
    if (bus.reg_en)       en_cnt    <= en_cnt + 1;
    if (bus.reg_catch_in) catch_cnt <= catch_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic l);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      if (bus.result_valid) stray = 1'b1;
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic send_frame1(input logic [7:0] a);
    exp_q.push_back(int'(a) % MODULUS);
    send_byte(a, 1'b1);
  endtask

  task automatic send_frame2(input logic [7:0] a,
                             input logic [7:0] b);
    exp_q.push_back((int'(a) * 256 + int'(b)) % MODULUS);
    send_byte(a, 1'b0);
    send_byte(b, 1'b1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.result_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.result_valid) check("result_timeout", 0, 1);
  endtask

  task automatic compare_result(input string tag);
    int unsigned e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rem"}, 32'(bus.result_remainder), e);
      check({tag, "_div"}, 32'(bus.result_divisible),
            32'(e == 0));
    end
  endtask

  task automatic ack();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int lat;
    wait_valid(lat);
    compare_result(tag);
    ack();
  endtask

  initial begin
    int lat;
    int e0;
    int c0;
    logic stable;
    logic [REM_WIDTH-1:0] held;

    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.result_ready = 1'b0;

    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_reg_en", 32'(bus.reg_en), 0);
    check("rst_catch", 32'(bus.reg_catch_in), 0);
    check("rst_pin", 32'(bus.reg_parallel_in), 0);
    check("rst_valid", 32'(bus.result_valid), 0);
    check("rst_rem", 32'(bus.result_remainder), 0);
    check("rst_div", 32'(bus.result_divisible), 1);
    reset_n = 1'b1;
    tick();

    // 0x0A: latency, load pulse and enable count
    e0 = en_cnt;
    c0 = catch_cnt;
    send_frame1(8'h0A);
    wait_valid(lat);
    check("0a_latency", 32'(lat), 10);
    check("0a_en_cycles", 32'(en_cnt - e0), 9);
    check("0a_catch", 32'(catch_cnt - c0), 1);
    check("0a_in_ready", 32'(bus.in_ready), 0);
    compare_result("0a");
    ack();
    check("0a_ack_valid", 32'(bus.result_valid), 0);
    check("0a_ack_ready", 32'(bus.in_ready), 1);

    send_frame1(8'h07);
    get_result("07");
    send_frame1(8'hFF);
    get_result("ff");

    stray = 1'b0;
    send_frame2(8'h03, 8'hE8);
    check("f1000_no_mid", 32'(stray), 0);
    get_result("f1000");

    stray = 1'b0;
    send_frame2(8'h01, 8'h00);
    check("f256_no_mid", 32'(stray), 0);
    get_result("f256");

    // backpressure with ignored input pulses
    send_frame1(8'h07);
    wait_valid(lat);
    held   = bus.result_remainder;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = $urandom;
      bus.in_last  = 1'b1;
      tick();
      if (!bus.result_valid ||
          bus.result_remainder != held ||
          bus.in_ready)
        stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("bp_stable", 32'(stable), 1);
    compare_result("bp");
    ack();
    check("bp_rel_ready", 32'(bus.in_ready), 1);
    send_frame1(8'h0A);
    get_result("bp_next");

    // in_valid held through SHIFT with changing data
    exp_q.push_back(2);
    send_byte(8'h07, 1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = $urandom;
      bus.in_last = i[0];
      tick();
    end
    bus.in_valid = 1'b0;
    get_result("hold");
    repeat (15) tick();
    check("hold_no_extra", 32'(bus.result_valid), 0);

    // reset in SHIFT counter 4 discards partial frame
    send_byte(8'hE7, 1'b1);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("mid_rst_en", 32'(bus.reg_en), 0);
    check("mid_rst_valid", 32'(bus.result_valid), 0);
    check("mid_rst_ready", 32'(bus.in_ready), 1);
    reset_n = 1'b1;
    tick();
    send_frame1(8'h05);
    get_result("after_rst");

    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
